// File: rtl/sdad_pkg.sv
// Shared definitions for the sigma-delta ADC decimator: defaults, FSM states, helpers.
package sdad_pkg;

  localparam int C_CLK_FRQ_DEF    = 100_000_000;
  localparam int C_MOD_FRQ_DEF    = 1_000_000;
  localparam int C_OSR_DEF        = 256;
  localparam int C_DATA_WIDTH_DEF = 8;

  // IDLE: loop stopped; SETTLE: first window is thrown away; RUN: windows are published.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdad_if.sv
// Sample handshake between the decimator (master) and its consumer (slave).
interface sdad_if
  import sdad_pkg::*;
#(
  parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF
) ();

  logic                    valid;
  logic                    ack;
  logic [C_DATA_WIDTH-1:0] data;
  logic                    error;

  modport master (
    output valid,
    output data,
    output error,
    input  ack
  );

  modport slave (
    input  valid,
    input  data,
    input  error,
    output ack
  );

endinterface

// File: rtl/sdad_tick.sv
// Divides the system clock down to a one-cycle modulator tick strobe.
module sdad_tick
  import sdad_pkg::*;
#(
  parameter int C_CLK_FRQ = C_CLK_FRQ_DEF,
  parameter int C_MOD_FRQ = C_MOD_FRQ_DEF
) (
  input  logic rstb,
  input  logic clk,
  input  logic enable,
  output logic tick
);

  localparam int DIV   = C_CLK_FRQ / C_MOD_FRQ;
  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);

  logic [CNT_W-1:0] cnt;

  // The strobe is gated by enable so no tick can slip out while the loop is stopped.
  assign tick = enable && (cnt == CNT_W'(DIV - 1));

  // Free-running divider, parked at zero whenever the loop is disabled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdad_decimator.sv
// First-order sigma-delta loop closure plus boxcar decimator with a valid/ack output.
module sdad_decimator
  import sdad_pkg::*;
#(
  parameter int C_CLK_FRQ    = C_CLK_FRQ_DEF,
  parameter int C_MOD_FRQ    = C_MOD_FRQ_DEF,
  parameter int C_OSR        = C_OSR_DEF,
  parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   enable,
  input  logic   cmp,
  output logic   fb,
  sdad_if.master smp
);

  localparam int LOG2_OSR = clog2(C_OSR);
  localparam int CNT_W    = LOG2_OSR + 1;
  localparam int SHIFT    = LOG2_OSR - C_DATA_WIDTH;
  localparam int SAT      = (1 << LOG2_OSR) - 1;

  logic                    cmp_meta;
  logic                    cmp_sync;
  logic                    tick;
  logic                    window_end;
  logic [LOG2_OSR-1:0]     tick_cnt;
  logic [CNT_W-1:0]        ones_cnt;
  logic [LOG2_OSR-1:0]     sat_cnt;
  logic [C_DATA_WIDTH-1:0] result;
  logic                    publish;
  logic                    valid_q;
  logic [C_DATA_WIDTH-1:0] data_q;
  logic                    error_q;
  state_t                  state;
  state_t                  state_next;

  sdad_tick #(
    .C_CLK_FRQ (C_CLK_FRQ),
    .C_MOD_FRQ (C_MOD_FRQ)
  ) u_tick (
    .rstb   (rstb),
    .clk    (clk),
    .enable (enable),
    .tick   (tick)
  );

  // Two-flop synchronizer: the comparator toggles with no relation to clk.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cmp_meta <= 1'b0;
      cmp_sync <= 1'b0;
    end else begin
      cmp_meta <= cmp;
      cmp_sync <= cmp_meta;
    end
  end

  assign window_end = tick && (tick_cnt == LOG2_OSR'(C_OSR - 1));

  // A full window of all ones counts OSR, one more than the output range holds.
  assign sat_cnt = (ones_cnt > CNT_W'(SAT)) ? LOG2_OSR'(SAT) : ones_cnt[LOG2_OSR-1:0];
  assign result  = C_DATA_WIDTH'(sat_cnt >> SHIFT);

  // Loop feedback and window accumulation; the closing tick's bit seeds the next window.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fb       <= 1'b0;
      tick_cnt <= '0;
      ones_cnt <= '0;
    end else if (!enable) begin
      fb       <= 1'b0;
      tick_cnt <= '0;
      ones_cnt <= '0;
    end else if (tick) begin
      fb       <= cmp_sync;
      tick_cnt <= tick_cnt + 1'b1;
      if (window_end) begin
        ones_cnt <= CNT_W'(cmp_sync);
      end else begin
        ones_cnt <= ones_cnt + CNT_W'(cmp_sync);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, and whether the closing window gets published.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (window_end) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (window_end) begin
          publish = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output holding register; a publish overrides a same-cycle ack, and overrun is sticky.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else if (publish) begin
      data_q  <= result;
      valid_q <= 1'b1;
      if (valid_q && !smp.ack) error_q <= 1'b1;
    end else if (valid_q && smp.ack) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end
  end

  assign smp.valid = valid_q;
  assign smp.data  = data_q;
  assign smp.error = error_q;

endmodule

// File: tb/tb_sdad_decimator.sv
// Self-checking bench for sdad_decimator: pattern table, random bits vs window model, handshake corners.
module tb_sdad_decimator;

  localparam int DIV    = 10;
  localparam int WIN    = 16;
  localparam int TB_DW  = 4;
  localparam int TB_LOG = 4;

  typedef struct {
    int mode;
    int exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  logic enable = 1'b0;
  logic cmp = 1'b0;
  logic ack_drv = 1'b0;
  logic fb;
  bit   ack_idle = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;
  int n_tick = 0;
  bit hist[$];

  sdad_if #(.C_DATA_WIDTH(TB_DW)) bus ();
  assign bus.ack = ack_drv;

  sdad_decimator #(
    .C_CLK_FRQ    (100_000_000),
    .C_MOD_FRQ    (10_000_000),
    .C_OSR        (16),
    .C_DATA_WIDTH (TB_DW)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .enable (enable),
    .cmp    (cmp),
    .fb     (fb),
    .smp    (bus)
  );

  always #5 clk = ~clk;

  // Expected sample for the window that closes on tick end_tick (ticks numbered from 1).
  // That window holds the bits of ticks end_tick-16 .. end_tick-1.
  function automatic int model_window(input int end_tick);
    int sum;
    int sat;
    sum = 0;
    for (int k = end_tick - 17; k <= end_tick - 2; k++) sum += int'(hist[k]);
    sat = (sum > (1 << TB_LOG) - 1) ? (1 << TB_LOG) - 1 : sum;
    return sat >> (TB_LOG - TB_DW);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One modulator period: bit b is presented early so it is settled through the synchronizer
  // by the tick; ack pulses for one clock at ack_phase (phase 9 lands on the tick edge).
  task automatic applyStimulus(input bit b, input int ack_phase);
    for (int i = 0; i < DIV; i++) begin
      ack_drv = (i == ack_phase) ? 1'b1 : ack_idle;
      if (i == 2) cmp = b;
      @(negedge clk);
    end
    n_tick++;
    hist.push_back(b);
  endtask

  task automatic pulse_reset(input bit hold_enable);
    #2 rstb = 1'b0;
    #1;
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_data", bus.data, 0);
    checkOutput("rst_error", bus.error, 0);
    checkOutput("rst_fb", fb, 0);
    if (!hold_enable) enable = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    hist.delete();
    n_tick = 0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    hist.delete();
    n_tick = 0;
  endtask

  task automatic rand_ticks(input int count);
    for (int k = 0; k < count; k++) applyStimulus(1'($urandom_range(0, 1)), -1);
  endtask

  // mode 0: zeros, 1: ones, 2: toggling, 3: random; exp_fixed < 0 selects the model.
  task automatic run_ticks(input int mode, input int count, input int exp_fixed);
    bit b;
    int expv;
    for (int k = 0; k < count; k++) begin
      case (mode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = 1'((n_tick + 1) % 2);
        default: b = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(b, -1);
      if (n_tick % WIN == 0) begin
        if (n_tick == WIN) begin
          checkOutput("settle_valid", bus.valid, 0);
        end else begin
          expv = (exp_fixed >= 0) ? exp_fixed : model_window(n_tick);
          checkOutput($sformatf("win%0d_valid", n_tick), bus.valid, 1);
          checkOutput($sformatf("win%0d_data", n_tick), bus.data, expv);
          checkOutput($sformatf("win%0d_error", n_tick), bus.error, 0);
        end
      end else if (ack_idle && (n_tick % WIN == WIN - 1) && (n_tick > WIN)) begin
        checkOutput($sformatf("pre%0d_valid", n_tick + 1), bus.valid, 0);
      end
    end
  endtask

  initial begin
    vec_t vecs[3];
    int exp96;

    vecs[0] = '{mode: 1, exp_data: 15};
    vecs[1] = '{mode: 0, exp_data: 0};
    vecs[2] = '{mode: 2, exp_data: 8};

    @(negedge clk);
    pulse_reset(1'b0);

    $display("[TB] constant pattern table");
    for (int v = 0; v < 3; v++) begin
      pulse_reset(1'b0);
      ack_idle = 1'b1;
      start_run();
      run_ticks(vecs[v].mode, 3 * WIN, vecs[v].exp_data);
    end

    $display("[TB] random bitstream against window model");
    pulse_reset(1'b0);
    ack_idle = 1'b1;
    start_run();
    run_ticks(3, 6 * WIN, -1);

    $display("[TB] overrun, ack on window end, single ack");
    pulse_reset(1'b0);
    ack_idle = 1'b0;
    start_run();
    rand_ticks(32);
    checkOutput("ov32_valid", bus.valid, 1);
    checkOutput("ov32_data", bus.data, model_window(32));
    checkOutput("ov32_error", bus.error, 0);
    rand_ticks(16);
    checkOutput("ov48_valid", bus.valid, 1);
    checkOutput("ov48_data", bus.data, model_window(48));
    checkOutput("ov48_error", bus.error, 1);
    rand_ticks(15);
    applyStimulus(1'($urandom_range(0, 1)), 9);
    checkOutput("ackend64_valid", bus.valid, 1);
    checkOutput("ackend64_data", bus.data, model_window(64));
    checkOutput("ackend64_error", bus.error, 1);
    applyStimulus(1'($urandom_range(0, 1)), 4);
    checkOutput("ack65_valid", bus.valid, 0);
    checkOutput("ack65_error", bus.error, 0);
    rand_ticks(15);
    checkOutput("w80_valid", bus.valid, 1);
    checkOutput("w80_data", bus.data, model_window(80));
    checkOutput("w80_error", bus.error, 0);
    rand_ticks(15);
    applyStimulus(1'($urandom_range(0, 1)), 9);
    exp96 = model_window(96);
    checkOutput("ackend96_valid", bus.valid, 1);
    checkOutput("ackend96_data", bus.data, exp96);
    checkOutput("ackend96_error", bus.error, 0);

    $display("[TB] enable dropped mid-window with a pending sample");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, -1);
    checkOutput("predrop_fb", fb, 1);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("drop_fb", fb, 0);
    checkOutput("drop_valid", bus.valid, 1);
    checkOutput("drop_data", bus.data, exp96);
    repeat (5) @(negedge clk);
    checkOutput("idle_valid", bus.valid, 1);
    checkOutput("idle_data", bus.data, exp96);
    ack_drv = 1'b1;
    @(negedge clk);
    ack_drv = 1'b0;
    checkOutput("idle_ack_valid", bus.valid, 0);
    checkOutput("idle_ack_error", bus.error, 0);
    ack_idle = 1'b1;
    start_run();
    run_ticks(1, 2 * WIN, 15);

    $display("[TB] reset pulsed mid-window");
    pulse_reset(1'b0);
    ack_idle = 1'b0;
    start_run();
    for (int k = 0; k < 40; k++) applyStimulus(1'b1, -1);
    checkOutput("prerst_valid", bus.valid, 1);
    checkOutput("prerst_data", bus.data, 15);
    pulse_reset(1'b1);
    ack_idle = 1'b1;
    run_ticks(2, 3 * WIN, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
